// File: rtl/btn_event_queue.sv
// Button front end: per-button 2-FF sync, debounce and rising-edge pulse, then a
// pending/arbiter stage feeding a 4-deep event FIFO with a valid/ready pop port.
module btn_event_queue #(
    parameter int DB_CYCLES = 2,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNC,
    input  logic       evt_ready,
    input  logic       ovf_clr,
    output logic [4:0] btn_pulse,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic [2:0] evt_count,
    output logic       ovf
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [4:0]       raw_s;
    logic [4:0]       sync1_r, sync2_r, db_r, db_d_r, pulse_r, pend_r;
    logic [CNT_W-1:0] cnt_r [5];
    logic [2:0]       mem_r [4];
    logic [1:0]       wr_ptr_r, rd_ptr_r;
    logic [2:0]       count_r, count_nxt_s;
    logic             valid_r, ovf_r;
    logic [2:0]       sel_s;
    logic [4:0]       sel_oh_s, clr_s, lost_s;
    logic             full_s, pop_s, push_s;

    assign raw_s     = {BTNC, BTND, BTNU, BTNR, BTNL};
    assign btn_pulse = pulse_r;
    assign evt_valid = valid_r;
    assign evt_count = count_r;
    assign ovf       = ovf_r;

    // Synchroniser, debounce counters and press-edge pulse generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 5'b0;
            sync2_r <= 5'b0;
            db_r    <= 5'b0;
            db_d_r  <= 5'b0;
            pulse_r <= 5'b0;
            for (int i = 0; i < 5; i++) cnt_r[i] <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            db_d_r  <= db_r;
            pulse_r <= db_r & ~db_d_r;
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] != db_r[i]) begin
                    if (cnt_r[i] == DB_LAST) begin
                        db_r[i]  <= sync2_r[i];
                        cnt_r[i] <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_r[i] <= '0;
                end
            end
        end
    end

    // Fixed-priority pick of the lowest pending button.
    always_comb begin
        sel_s    = 3'd0;
        sel_oh_s = 5'b00000;
        casez (pend_r)
            5'b????1: begin sel_s = 3'd0; sel_oh_s = 5'b00001; end
            5'b???10: begin sel_s = 3'd1; sel_oh_s = 5'b00010; end
            5'b??100: begin sel_s = 3'd2; sel_oh_s = 5'b00100; end
            5'b?1000: begin sel_s = 3'd3; sel_oh_s = 5'b01000; end
            5'b10000: begin sel_s = 3'd4; sel_oh_s = 5'b10000; end
            default:  begin sel_s = 3'd0; sel_oh_s = 5'b00000; end
        endcase
    end

    assign full_s = (count_r == 3'd4);
    assign pop_s  = valid_r & evt_ready;
    assign push_s = (pend_r != 5'b0) & (~full_s | pop_s);
    assign clr_s  = push_s ? sel_oh_s : 5'b0;
    // A press is only lost if its earlier event is still waiting after this cycle.
    assign lost_s = pulse_r & pend_r & ~clr_s;

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 3'd1;
            2'b01:   count_nxt_s = count_r - 3'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Head entry is presented directly; an empty FIFO shows code 0.
    always_comb begin
        if (count_r != 3'd0) begin
            evt_code = mem_r[rd_ptr_r];
        end else begin
            evt_code = 3'd0;
        end
    end

    // Pending bits, FIFO storage/pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r   <= 5'b0;
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
            for (int i = 0; i < 4; i++) mem_r[i] <= 3'd0;
        end else begin
            pend_r  <= (pend_r & ~clr_s) | pulse_r;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 3'd0);
            if (push_s) begin
                mem_r[wr_ptr_r] <= sel_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (lost_s != 5'b0) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue: expected events go into a scoreboard queue,
// a monitor compares every popped head code against it.
module tb_btn_event_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn = 5'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [4:0] btn_pulse;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [2:0] evt_count;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [5] = '{0, 0, 0, 0, 0};
    logic [2:0] exp_q [$];

    btn_event_queue #(.DB_CYCLES(2), .CNT_W(20)) dut (
        .clk(clk), .rst(rst),
        .BTNL(btn[0]), .BTNR(btn[1]), .BTNU(btn[2]), .BTND(btn[3]), .BTNC(btn[4]),
        .evt_ready(evt_ready), .ovf_clr(ovf_clr),
        .btn_pulse(btn_pulse), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_count(evt_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx, input int hi, input int gap);
        btn[idx] = 1'b1;
        tick(hi);
        btn[idx] = 1'b0;
        tick(gap);
    endtask

    task automatic pop(input int n);
        evt_ready = 1'b1;
        tick(n);
        evt_ready = 1'b0;
    endtask

    // Monitor: counts pulses and checks every accepted head event.
    initial begin
        logic [2:0] exp;
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < 5; i++) pulse_cnt[i] += int'(btn_pulse[i]);
            if (evt_valid && evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got code %0d expected no event at %0t", evt_code, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (evt_code !== exp) begin
                        errors++;
                        $display("FAIL pop_code: got %0d expected %0d at %0t", evt_code, exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        int p0;
        tick(2);
        check("rst_pulse", {3'b0, btn_pulse}, 8'h00);
        check("rst_valid", {7'b0, evt_valid}, 8'h00);
        check("rst_count", {5'b0, evt_count}, 8'h00);
        check("rst_ovf", {7'b0, ovf}, 8'h00);
        rst = 1'b1;
        tick(2);

        // 1: single press of L, pulse timing and queued event
        btn[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 4) btn[0] = 1'b0;
            check($sformatf("t1_pulse_k%0d", k), {7'b0, btn_pulse[0]}, (k == 5) ? 8'h01 : 8'h00);
        end
        exp_q.push_back(3'd0);
        tick(3);
        check("t1_valid", {7'b0, evt_valid}, 8'h01);
        check("t1_code", {5'b0, evt_code}, 8'h00);
        check("t1_count", {5'b0, evt_count}, 8'h01);
        pop(1);
        check("t1_count_after_pop", {5'b0, evt_count}, 8'h00);

        // 2: one-cycle glitch on U is filtered
        p0 = pulse_cnt[2];
        press(2, 1, 8);
        check("t2_no_pulse", 8'(pulse_cnt[2] - p0), 8'h00);
        check("t2_count", {5'b0, evt_count}, 8'h00);

        // 3: L R U C queued, then drained in order; ready while empty is harmless
        press(0, 4, 5); exp_q.push_back(3'd0);
        press(1, 4, 5); exp_q.push_back(3'd1);
        press(2, 4, 5); exp_q.push_back(3'd2);
        press(4, 4, 5); exp_q.push_back(3'd4);
        tick(4);
        check("t3_count_full", {5'b0, evt_count}, 8'h04);
        pop(6);
        check("t3_valid_empty", {7'b0, evt_valid}, 8'h00);
        check("t3_count_empty", {5'b0, evt_count}, 8'h00);
        check("t3_code_empty", {5'b0, evt_code}, 8'h00);

        // 4: R and D pressed together
        btn[1] = 1'b1;
        btn[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 4) begin btn[1] = 1'b0; btn[3] = 1'b0; end
            if (k == 5) check("t4_pulses", {3'b0, btn_pulse}, 8'h0A);
            if (k == 6) check("t4_pulses_gone", {3'b0, btn_pulse}, 8'h00);
            if (k == 7) begin
                check("t4_count1", {5'b0, evt_count}, 8'h01);
                check("t4_head_r", {5'b0, evt_code}, 8'h01);
            end
            if (k == 8) check("t4_count2", {5'b0, evt_count}, 8'h02);
        end
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        check("t4_ovf", {7'b0, ovf}, 8'h00);
        tick(3);
        pop(2);

        // 5: full FIFO, C held pending, second C overflows
        press(0, 4, 5); exp_q.push_back(3'd0);
        press(1, 4, 5); exp_q.push_back(3'd1);
        press(2, 4, 5); exp_q.push_back(3'd2);
        press(3, 4, 5); exp_q.push_back(3'd3);
        tick(3);
        check("t5_full", {5'b0, evt_count}, 8'h04);
        press(4, 4, 8); exp_q.push_back(3'd4);
        check("t5_ovf_first", {7'b0, ovf}, 8'h00);
        press(4, 4, 8);
        check("t5_ovf_set", {7'b0, ovf}, 8'h01);
        check("t5_still_full", {5'b0, evt_count}, 8'h04);
        pop(1);
        check("t5_count_after_swap", {5'b0, evt_count}, 8'h04);
        check("t5_head_after_swap", {5'b0, evt_code}, 8'h01);
        tick(2);
        check("t5_ovf_sticky", {7'b0, ovf}, 8'h01);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_ovf_cleared", {7'b0, ovf}, 8'h00);
        pop(4);
        check("t5_drained", {5'b0, evt_count}, 8'h00);

        // 6: reset mid-debounce with an event queued, C held across reset
        press(0, 4, 5);
        tick(2);
        check("t6_pre_count", {5'b0, evt_count}, 8'h01);
        btn[4] = 1'b1;
        tick(2);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_valid", {7'b0, evt_valid}, 8'h00);
        check("t6_rst_count", {5'b0, evt_count}, 8'h00);
        check("t6_rst_pulse", {3'b0, btn_pulse}, 8'h00);
        check("t6_rst_code", {5'b0, evt_code}, 8'h00);
        tick(3);
        check("t6_rst_hold_ovf", {7'b0, ovf}, 8'h00);
        check("t6_rst_hold_count", {5'b0, evt_count}, 8'h00);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check($sformatf("t6_pulse_k%0d", k), {7'b0, btn_pulse[4]}, (k == 5) ? 8'h01 : 8'h00);
        end
        exp_q.push_back(3'd4);
        btn[4] = 1'b0;
        tick(3);
        check("t6_count", {5'b0, evt_count}, 8'h01);
        check("t6_code", {5'b0, evt_code}, 8'h04);
        pop(1);
        tick(2);
        check("sb_empty", 8'(exp_q.size()), 8'h00);
        check("final_count", {5'b0, evt_count}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Upstream input stage for the parking controller top.
- Takes the five raw push buttons (BTNL, BTNR, BTNU, BTND, BTNC) and synchronises, debounces and edge-detects each one.
- Queues one coded event per press into a 4-deep FIFO. The parking FSM pops events through a valid/ready handshake, so it never sees bounce, and back-to-back or simultaneous presses are not lost.

Parameters:
- DB_CYCLES, 2, consecutive synchronised cycles a new level must hold before the debounced state flips (1..2^CNT_W-1). Board top overrides to about 1,000,000.
- CNT_W, 20, debounce counter width per button.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- BTNL  input  1  raw left button, active-high
- BTNR  input  1  raw right button
- BTNU  input  1  raw up button
- BTND  input  1  raw down button
- BTNC  input  1  raw centre button
- evt_ready  input  1  consumer accepts the head event this cycle
- ovf_clr  input  1  clears ovf, synchronous
- btn_pulse  output  5  one-cycle press pulse per button: [0]=L, [1]=R, [2]=U, [3]=D, [4]=C
- evt_valid  output  1  FIFO non-empty
- evt_code  output  3  head event: L=0, R=1, U=2, D=3, C=4. Values 5..7 never emitted.
- evt_count  output  3  FIFO occupancy, 0..4
- ovf  output  1  sticky: a press was lost

Behaviour:
- Reset (rst=0, async): every output is 0. Sync flops, debounced states (released), counters, pending bits, FIFO pointers and count are all 0.
- Synchroniser: 2-FF per button. s[i] is the raw value delayed 2 clocks.
- Debounce, per button:
  - If s[i] != db[i], cnt increments; otherwise cnt is 0.
  - When cnt == DB_CYCLES-1 and s[i] != db[i]: db[i] <= s[i] and cnt <= 0.
  - Any glitch shorter than DB_CYCLES synchronised cycles is ignored.
- Pulse: btn_pulse[i] = 1 for exactly one cycle, the cycle after db[i] rises 0->1. No pulse on release.
- Latency: a raw level first sampled at edge N gives btn_pulse high after edge N+1+DB_CYCLES+1, i.e. DB_CYCLES+2 cycles.
- Pending register pend[4:0]:
  - Set by btn_pulse[i].
  - Cleared when that button's event is pushed.
  - Pulse on a button whose pend bit is already set: ovf <= 1, event merged (lost).
- Push arbitration:
  - At most one push per cycle.
  - Picks the lowest-index set pend bit (L > R > U > D > C).
  - Pushes only if the FIFO is not full, or a pop happens in the same cycle.
  - A pulse sets pend the same cycle, so the push of that event occurs on the following cycle at the earliest.
- FIFO: 4 entries, 2-bit read/write pointers wrapping 3->0.
  - Pop when evt_valid && evt_ready.
  - evt_code is combinational from the head entry; it is 0 when empty.
  - evt_ready while empty is ignored: no underflow, count stays 0.
  - Full + pop + push in the same cycle: both occur, count stays 4.
  - Empty + push: evt_valid goes high the next cycle. There is no same-cycle bypass.
- ovf: set as above, cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Button held across reset release: db=0 after reset, so after DB_CYCLES+2 cycles it is reported as a new press.
- Reset asserted mid-debounce or with a non-empty FIFO: everything is discarded immediately. No events survive.

Test Plan (clk period 10 ns, DB_CYCLES=2):
1. Press BTNL high for 37 ns, evt_ready=0 -> btn_pulse[0] high exactly one cycle, 4 cycles after the first sampling edge. Then evt_valid=1, evt_code=0, evt_count=1.
2. BTNU high for one cycle only (glitch) -> no btn_pulse, evt_count stays 0.
3. Sequence L, R, U, C (37 ns presses, 52 ns gaps), evt_ready=0 -> evt_count=4. Pops with evt_ready=1 yield codes 0, 1, 2, 4 in order, then evt_valid=0.
4. BTNR and BTND rise on the same edge -> pulses in the same cycle. Events queue as 1 then 3 on consecutive cycles, ovf=0.
5. FIFO full, evt_ready=0, press C, then press C again -> first C is held pending, second C sets ovf=1. Pop once -> code 4 enters the FIFO and count returns to 4. ovf_clr -> ovf=0.
6. Hold BTNC, pulse rst low for 3 cycles mid-debounce -> all outputs 0 during reset. After release, btn_pulse[4] fires DB_CYCLES+2 cycles later.
